// File: rtl/mem_arbiter_if.sv
// Bundles the two requester ports and the RAM port of the memory arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// whatever sits on the other side: the datapath/cache and the RAM model.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-fetch requester
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              ihit;
  logic [DATA_W-1:0] iload;
  // data requester
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dhit;
  logic [DATA_W-1:0] dload;
  // single-ported RAM
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ram_ready;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter that shares one single-ported RAM between instruction fetch and
// data accesses. Data accesses have priority. A saturating streak counter
// caps how many data grants in a row can pass a waiting fetch. Every access
// runs IDLE -> grant -> IDLE, so at most one access completes every 2 cycles.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);
  localparam int             SW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]  LIM = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic              wr_q, wr_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              dreq;

  // A simultaneous dREN and dWEN counts as a write, so either bit is a data request.
  assign dreq = bus.dREN | bus.dWEN;

  // State and latched access registers. Reset drops any in-flight access.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      store_q  <= '0;
      wr_q     <= 1'b0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      wr_q     <= wr_d;
      streak_q <= streak_d;
    end
  end

  // Grant decision, operand capture on grant entry, and streak bookkeeping.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    store_d  = store_q;
    wr_d     = wr_q;
    streak_d = streak_q;
    case (state_q)
      IDLE: begin
        // Without a waiting fetch there is nothing to starve.
        if (!bus.iREN) streak_d = '0;
        if (dreq && (!bus.iREN || streak_q < LIM)) begin
          state_d = DGNT;
          addr_d  = bus.daddr;
          store_d = bus.dstore;
          wr_d    = bus.dWEN;
        end else if (bus.iREN) begin
          state_d = IGNT;
          addr_d  = bus.iaddr;
          wr_d    = 1'b0;
        end
      end
      IGNT: begin
        if (bus.ram_ready) begin
          state_d  = IDLE;
          streak_d = '0;
        end
      end
      DGNT: begin
        // A completed data access counts even if the requester withdrew.
        if (bus.ram_ready) begin
          state_d = IDLE;
          if (streak_q != LIM) streak_d = streak_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM drive comes only from latched registers. A hit needs the requester still asking.
  always_comb begin
    bus.ramREN   = (state_q == IGNT) || ((state_q == DGNT) && !wr_q);
    bus.ramWEN   = (state_q == DGNT) && wr_q;
    bus.ramaddr  = addr_q;
    bus.ramstore = store_q;
    bus.ihit     = (state_q == IGNT) && bus.ram_ready && bus.iREN;
    bus.dhit     = (state_q == DGNT) && bus.ram_ready && dreq;
    bus.iload    = bus.ramload;
    bus.dload    = bus.ramload;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. A transaction-level reference model follows the
// arbitration rules, and its expected outputs are compared every cycle.
// Directed scenarios run first, then randomized requester/RAM traffic.
module tb_mem_arbiter;
  localparam int LIM = 4;

  logic CLK;
  logic nRST;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: the access in flight, if any, and the count of data accesses since the last fetch.
  bit          m_busy;
  bit          m_data;
  bit          m_wr;
  logic [31:0] m_addr;
  logic [31:0] m_store;
  int          m_ds;
  bit          last_ih, last_dh;
  bit          hitlog[$];

  // Check one cycle against the model, advance the model, then move to just after the next edge.
  task automatic step();
    bit e_ren, e_wen, e_ih, e_dh, dreq;
    #2;
    e_ren = 0; e_wen = 0; e_ih = 0; e_dh = 0;
    if (!nRST) begin
      chk("rst_addr", bus.ramaddr, 32'h0);
      chk("rst_store", bus.ramstore, 32'h0);
    end else if (m_busy) begin
      if (!m_data) begin
        e_ren = 1;
        e_ih  = bus.ram_ready & bus.iREN;
      end else begin
        e_wen = m_wr;
        e_ren = !m_wr;
        e_dh  = bus.ram_ready & (bus.dREN | bus.dWEN);
      end
      chk("ramaddr", bus.ramaddr, m_addr);
      if (m_data && m_wr) chk("ramstore", bus.ramstore, m_store);
    end
    chk("ramREN", {31'b0, bus.ramREN}, {31'b0, e_ren});
    chk("ramWEN", {31'b0, bus.ramWEN}, {31'b0, e_wen});
    chk("ihit", {31'b0, bus.ihit}, {31'b0, e_ih});
    chk("dhit", {31'b0, bus.dhit}, {31'b0, e_dh});
    if (e_ih) chk("iload", bus.iload, bus.ramload);
    if (e_dh) chk("dload", bus.dload, bus.ramload);
    if (bus.ihit) hitlog.push_back(1'b0);
    if (bus.dhit) hitlog.push_back(1'b1);
    last_ih = e_ih;
    last_dh = e_dh;
    // advance model for the coming edge
    if (!nRST) begin
      m_busy = 0;
      m_ds   = 0;
    end else if (m_busy) begin
      if (bus.ram_ready) begin
        m_busy = 0;
        if (m_data) m_ds = (m_ds < LIM) ? m_ds + 1 : LIM;
        else        m_ds = 0;
      end
    end else begin
      dreq = bus.dREN | bus.dWEN;
      if (dreq && (!bus.iREN || m_ds < LIM)) begin
        m_busy = 1; m_data = 1; m_wr = bus.dWEN;
        m_addr = bus.daddr; m_store = bus.dstore;
      end else if (bus.iREN) begin
        m_busy = 1; m_data = 0; m_wr = 0;
        m_addr = bus.iaddr;
      end
      if (!bus.iREN) m_ds = 0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic look();
    #1;
  endtask

  bit i_act, d_act;

  initial begin
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ram_ready = 0;
    m_busy = 0; m_data = 0; m_wr = 0; m_addr = 0; m_store = 0; m_ds = 0;
    nRST = 1;
    #1 nRST = 0;
    step();
    step();
    nRST = 1;
    step();

    // single fetch
    bus.iREN = 1; bus.iaddr = 32'h40; bus.ram_ready = 1; bus.ramload = 32'h1234_5678;
    step();
    look();
    chk("sf_ren", {31'b0, bus.ramREN}, 32'h1);
    chk("sf_addr", bus.ramaddr, 32'h40);
    chk("sf_ihit", {31'b0, bus.ihit}, 32'h1);
    chk("sf_iload", bus.iload, 32'h1234_5678);
    step();
    bus.iREN = 0;
    look();
    chk("sf_idle", {31'b0, bus.ramREN}, 32'h0);
    step();

    // simultaneous fetch and data write: data goes first
    bus.iREN = 1; bus.iaddr = 32'h44;
    bus.dWEN = 1; bus.daddr = 32'h80; bus.dstore = 32'hDEAD_BEEF;
    step();
    look();
    chk("sim_wen", {31'b0, bus.ramWEN}, 32'h1);
    chk("sim_addr", bus.ramaddr, 32'h80);
    chk("sim_store", bus.ramstore, 32'hDEAD_BEEF);
    chk("sim_dhit", {31'b0, bus.dhit}, 32'h1);
    step();
    bus.dWEN = 0;
    look();
    chk("sim_gap", {31'b0, bus.ramREN | bus.ramWEN}, 32'h0);
    step();
    look();
    chk("sim_iaddr", bus.ramaddr, 32'h44);
    chk("sim_ihit", {31'b0, bus.ihit}, 32'h1);
    step();
    bus.iREN = 0;
    step();

    // anti-starvation: both held, expect four data completions per fetch
    hitlog.delete();
    bus.iREN = 1; bus.dREN = 1; bus.ram_ready = 1;
    repeat (30) step();
    bus.iREN = 0; bus.dREN = 0;
    step();
    chk("starve_cnt", hitlog.size(), 32'd15);
    for (int k = 0; k < hitlog.size(); k++)
      chk($sformatf("starve_seq%0d", k), {31'b0, hitlog[k]}, (k % 5 == 4) ? 32'h0 : 32'h1);

    // wait states during a fetch grant
    bus.iREN = 1; bus.iaddr = 32'h123; bus.ram_ready = 0;
    step();
    repeat (5) begin
      look();
      chk("ws_ren", {31'b0, bus.ramREN}, 32'h1);
      chk("ws_addr", bus.ramaddr, 32'h123);
      chk("ws_ihit", {31'b0, bus.ihit}, 32'h0);
      step();
    end
    bus.ram_ready = 1;
    look();
    chk("ws_hit", {31'b0, bus.ihit}, 32'h1);
    step();
    bus.iREN = 0;
    look();
    chk("ws_pulse", {31'b0, bus.ihit}, 32'h0);
    step();

    // data requester withdraws mid-grant
    bus.dREN = 1; bus.daddr = 32'h200; bus.ram_ready = 0;
    step();
    step();
    bus.dREN = 0; bus.ram_ready = 1;
    look();
    chk("wd_ren", {31'b0, bus.ramREN}, 32'h1);
    chk("wd_dhit", {31'b0, bus.dhit}, 32'h0);
    step();
    bus.ram_ready = 0;
    look();
    chk("wd_idle", {31'b0, bus.ramREN}, 32'h0);
    step();

    // reset in the middle of a data grant
    bus.dREN = 1; bus.daddr = 32'h300;
    step();
    step();
    bus.ram_ready = 1;
    nRST = 0;
    look();
    chk("mr_ren", {31'b0, bus.ramREN | bus.ramWEN}, 32'h0);
    chk("mr_dhit", {31'b0, bus.dhit}, 32'h0);
    chk("mr_addr", bus.ramaddr, 32'h0);
    step();
    nRST = 1; bus.dREN = 0;
    look();
    chk("mr_after", {31'b0, bus.dhit | bus.ihit}, 32'h0);
    repeat (3) step();

    // randomized traffic
    i_act = 0; d_act = 0;
    for (int c = 0; c < 3000; c++) begin
      nRST = ($urandom % 250 != 0);
      if (!i_act && $urandom % 3 == 0) begin
        i_act = 1; bus.iaddr = $urandom;
      end else if (i_act && $urandom % 12 == 0) bus.iaddr = $urandom;
      if (!d_act && $urandom % 3 == 0) begin
        d_act = 1; bus.daddr = $urandom; bus.dstore = $urandom;
        case ($urandom % 3)
          0: begin bus.dREN = 1; bus.dWEN = 0; end
          1: begin bus.dREN = 0; bus.dWEN = 1; end
          default: begin bus.dREN = 1; bus.dWEN = 1; end
        endcase
      end else if (d_act && $urandom % 12 == 0) bus.dstore = $urandom;
      if (i_act && $urandom % 30 == 0) i_act = 0;
      if (d_act && $urandom % 30 == 0) d_act = 0;
      bus.iREN = i_act;
      if (!d_act) begin bus.dREN = 0; bus.dWEN = 0; end
      bus.ram_ready = ($urandom % 3 != 0);
      bus.ramload = $urandom;
      step();
      if (last_ih || !nRST) i_act = 0;
      if (last_dh || !nRST) d_act = 0;
    end
    nRST = 1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
